// File: rtl/dram_rd_arb.sv
// ---------------------------------------------------------------------------
// dram_rd_arb
//   Shares the single registered read port of the image DRAM between two
//   pixel-fetch clients (round-robin). It also forwards one writer straight
//   to the DRAM write port.
//   Read grants are combinational. The DRAM returns data one cycle later, and
//   the response is steered to the client recorded in pend_id_q.
//   A read whose address matches a same-cycle write is held back one cycle.
//   As a result, every read observes post-write data.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   rq{0,1}_valid/addr/ready   client read request handshake
//   rs{0,1}_valid, rs_data     read response (shared data bus)
//   wr_valid/addr/data/ready   write request handshake (never stalls)
//   mem_ren/raddr/rdata        DRAM read port (1-cycle latency)
//   mem_wen/waddr/wdata        DRAM write port
// ---------------------------------------------------------------------------
module dram_rd_arb #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               rq0_valid,
    input  logic [A_WIDTH-1:0] rq0_addr,
    output logic               rq0_ready,
    input  logic               rq1_valid,
    input  logic [A_WIDTH-1:0] rq1_addr,
    output logic               rq1_ready,

    output logic               rs0_valid,
    output logic               rs1_valid,
    output logic [D_WIDTH-1:0] rs_data,

    input  logic               wr_valid,
    input  logic [A_WIDTH-1:0] wr_addr,
    input  logic [D_WIDTH-1:0] wr_data,
    output logic               wr_ready,

    output logic               mem_ren,
    output logic [A_WIDTH-1:0] mem_raddr,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               mem_wen,
    output logic [A_WIDTH-1:0] mem_waddr,
    output logic [D_WIDTH-1:0] mem_wdata
);

    logic               last_q, last_d;
    logic               pend_v_q, pend_v_d;
    logic               pend_id_q, pend_id_d;

    logic               cand_v;
    logic               cand_id;
    logic [A_WIDTH-1:0] cand_addr;
    logic               wr_fire;
    logic               stall;
    logic               grant;

    // Handshake outputs are qualified with rst_n directly, so nothing is
    // granted or written while reset is asserted. Outside reset the write
    // port is always ready.
    assign wr_ready  = rst_n;
    assign wr_fire   = wr_valid && wr_ready;
    assign mem_wen   = wr_fire;
    assign mem_waddr = rst_n ? wr_addr : '0;
    assign mem_wdata = rst_n ? wr_data : '0;

    always_comb begin
        cand_v    = rq0_valid || rq1_valid;
        // With both clients requesting, the one not served last wins.
        // Otherwise the lone requester is the candidate.
        cand_id   = (rq0_valid && rq1_valid) ? ~last_q : rq1_valid;
        cand_addr = cand_id ? rq1_addr : rq0_addr;
        // Hold a read that targets the address being written this cycle.
        // Next cycle the DRAM already holds the new data.
        stall     = wr_fire && (cand_addr == wr_addr);
        grant     = rst_n && cand_v && !stall;
    end

    assign rq0_ready = grant && !cand_id;
    assign rq1_ready = grant &&  cand_id;
    assign mem_ren   = grant;
    assign mem_raddr = grant ? cand_addr : '0;

    always_comb begin
        last_d    = last_q;
        pend_v_d  = grant;
        pend_id_d = pend_id_q;
        if (grant) begin
            last_d    = cand_id;
            pend_id_d = cand_id;
        end
    end

    // last_q resets to 1, so client 0 wins the first contended grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            pend_v_q  <= 1'b0;
            pend_id_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
        end
    end

    // The response path is purely registered state plus the data bus.
    // mem_rdata feeds no control output.
    assign rs0_valid = pend_v_q && !pend_id_q;
    assign rs1_valid = pend_v_q &&  pend_id_q;
    assign rs_data   = mem_rdata;

endmodule

// File: doc/dram_rd_arb.md
# dram_rd_arb

Read/write port arbiter for the 1 Mi × 8-bit image DRAM (20-bit address, registered read with 1-cycle latency, independent read and write ports). It shares the single read port round-robin between two pixel-fetch clients (e.g. filter window loader and display/readback path) and forwards one writer's stores to the write port. It also stalls a read that collides with a same-cycle write, so every read returns post-write data. It sits directly between the filter datapath and the DRAM model.

## Interface
- A_WIDTH, 20, address width
- D_WIDTH, 8, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rq0_valid / rq1_valid  in  1  client read request
- rq0_addr / rq1_addr  in  A_WIDTH  client read address
- rq0_ready / rq1_ready  out  1  request accepted this cycle (combinational grant)
- rs0_valid / rs1_valid  out  1  read data valid for client
- rs_data  out  D_WIDTH  read data, shared bus, qualified by rs0_valid/rs1_valid
- wr_valid  in  1  write request
- wr_addr  in  A_WIDTH  write address
- wr_data  in  D_WIDTH  write data
- wr_ready  out  1  write accepted this cycle (always 1 out of reset)
- mem_ren  out  1  DRAM read enable
- mem_raddr  out  A_WIDTH  DRAM read address
- mem_rdata  in  D_WIDTH  DRAM read data (valid the cycle after mem_ren)
- mem_wen  out  1  DRAM write enable
- mem_waddr  out  A_WIDTH  DRAM write address
- mem_wdata  out  D_WIDTH  DRAM write data

## Operation
- Handshake: a transfer occurs on a cycle with valid && ready. Clients hold valid and addr stable until ready. A dropped valid without ready is legal and simply withdraws the request.
- Writes: mem_wen = wr_valid && wr_ready; mem_waddr/mem_wdata = wr_addr/wr_data, combinational passthrough. wr_ready = 1 whenever not in reset. Writes always have priority and never stall.
- Read arbitration uses a round-robin pointer `last` (1 bit, the client granted most recently; reset 1, so client 0 wins first).
  - Only one client valid: that client is candidate.
  - Both valid: candidate is the client ≠ last.
  - Neither valid: no grant; `last` unchanged.
- Collision stall: if the candidate address equals wr_addr and the write handshakes this cycle, no grant is given. rq*_ready = 0, mem_ren = 0, `last` unchanged. The same candidate is re-evaluated next cycle.
- Grant: the candidate's ready = 1, mem_ren = 1, mem_raddr = candidate addr, `last` ← candidate. Exactly one rq*_ready is high per cycle at most.
- Response: register `pend_v` (reset 0) and `pend_id` (reset 0) capture the grant. On the following cycle rs{pend_id}_valid = pend_v and rs_data = mem_rdata. Responses cannot be back-pressured. Clients must sink them.
- Throughput: one read per cycle sustained. With both clients continuously valid and no collisions, grants alternate 0,1,0,1….
- Reset mid-operation: all registers clear asynchronously. An in-flight response is dropped (rs*_valid forced 0). Outstanding client requests are simply re-arbitrated after reset release.

## Timing
- Reset values: rq0_ready = rq1_ready = 0, wr_ready = 0, mem_ren = 0, mem_wen = 0, rs0_valid = rs1_valid = 0, rs_data = mem_rdata (unqualified), mem_raddr/mem_waddr/mem_wdata = 0.
- Grant is combinational in cycle N. DRAM samples raddr at edge N→N+1. rs*_valid and rs_data are valid in cycle N+1.
- Collision stall costs exactly one cycle per colliding write. A stalled read issued in N+1 returns the data written in N.
- Writes are observed by the DRAM at edge N→N+1 of the handshake cycle.
- No combinational path from mem_rdata to any control output.

## Test plan
- Single read: preload mem[0x00010] = 0xA5; rq0 valid addr 0x00010 at cycle 3 -> rq0_ready = 1 cycle 3, rs0_valid = 1 and rs_data = 0xA5 at cycle 4, rs1_valid = 0 throughout.
- Contention: rq0 addr 0x00001, rq1 addr 0x00002 both valid for 6 cycles after reset (mem holds 0x11, 0x22) -> grant order 0,1,0,1,0,1; responses alternate rs0 0x11 / rs1 0x22, one per cycle.
- Collision: mem[0x00040] = 0x00; same cycle wr 0x00040 ← 0x7E and rq1 valid 0x00040 -> rq1_ready = 0 that cycle, granted next cycle, rs1 returns 0x7E.
- Non-colliding concurrent write: wr 0x00050 ← 0x33 with rq0 read 0x00051 (0x44) same cycle -> no stall, rs0 returns 0x44 next cycle, later read of 0x00050 returns 0x33.
- Withdrawal and fairness: rq1 valid alone for 3 cycles, then rq0 joins -> next grant goes to rq0; rq1 drops valid without ready -> no spurious rs1_valid.
- Async reset mid-read: assert rst_n low between grant and response -> rs*_valid never pulses; after release, first contended grant goes to client 0.
